// File: rtl/exc_sched.sv
// exc_sched: commit-point arbiter and sequencer for exceptions, interrupts and ERTN towards the CSR file.
// Optional BADV update path is compiled in when EXC_BADV_EN is defined.
`timescale 1ns/1ps
module exc_sched #(
   parameter int DRAIN_CYCLES = 2
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        cmt_valid,
   output logic        cmt_ready,
   input  logic [31:0] cmt_pc,
   input  logic [5:0]  cmt_exc,
   input  logic        cmt_ertn,
   input  logic [31:0] cmt_badv,
   input  logic        int_pending,
   output logic        cmt_retire,
   output logic        exc_signal,
   output logic        ertn_signal,
   output logic [5:0]  exc_ecode,
   output logic [8:0]  exc_esubcode,
   output logic [31:0] exc_pc,
   output logic        flush,
   output logic        redirect_req,
   input  logic        redirect_ack,
   output logic        exc_badv_we,
   output logic [31:0] exc_badv
);

   typedef enum logic [1:0] {IDLE, TRAP, REDIRECT, DRAIN} state_t;

   localparam logic [5:0] ECODE_INT = 6'h00;
   localparam logic [5:0] ECODE_ADE = 6'h08;
   localparam logic [5:0] ECODE_ALE = 6'h09;
   localparam logic [5:0] ECODE_SYS = 6'h0B;
   localparam logic [5:0] ECODE_BRK = 6'h0C;
   localparam logic [5:0] ECODE_INE = 6'h0D;
   localparam logic [3:0] DRAIN_LOAD = (DRAIN_CYCLES > 0) ? 4'(DRAIN_CYCLES - 1) : 4'd0;

   state_t      state, state_nxt;
   logic [3:0]  drain_cnt;
   logic        accept;
   logic        sel_exc, sel_ertn, sel_badv;
   logic [5:0]  sel_ecode;
   logic [8:0]  sel_sub;
   logic [31:0] sel_badv_val;
   logic        is_exc_p1, is_ertn_p1;

   // Event arbitration on the commit slot: interrupt first, then the exception flags, then ERTN.
   always_comb begin
      sel_exc      = 1'b1;
      sel_ertn     = 1'b0;
      sel_badv     = 1'b0;
      sel_ecode    = ECODE_INT;
      sel_sub      = 9'd0;
      sel_badv_val = cmt_badv;
      if (int_pending) begin
         sel_ecode = ECODE_INT;
      end else if (cmt_exc[0]) begin
         sel_ecode    = ECODE_ADE;
         sel_badv     = 1'b1;
         sel_badv_val = cmt_pc;
      end else if (cmt_exc[1]) begin
         sel_ecode = ECODE_INE;
      end else if (cmt_exc[2]) begin
         sel_ecode = ECODE_BRK;
      end else if (cmt_exc[3]) begin
         sel_ecode = ECODE_SYS;
      end else if (cmt_exc[4]) begin
         sel_ecode = ECODE_ALE;
         sel_badv  = 1'b1;
      end else if (cmt_exc[5]) begin
         sel_ecode = ECODE_ADE;
         sel_sub   = 9'd1;
         sel_badv  = 1'b1;
      end else begin
         sel_exc  = 1'b0;
         sel_ertn = cmt_ertn;
      end
   end

   assign accept     = cmt_valid & cmt_ready;
   assign cmt_retire = accept & ~sel_exc & ~sel_ertn;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state        <= IDLE;
         drain_cnt    <= 4'd0;
         is_exc_p1    <= 1'b0;
         is_ertn_p1   <= 1'b0;
         exc_ecode    <= 6'd0;
         exc_esubcode <= 9'd0;
         exc_pc       <= 32'd0;
      end else begin
         state <= state_nxt;
         if (accept & (sel_exc | sel_ertn)) begin
            is_exc_p1    <= sel_exc;
            is_ertn_p1   <= sel_ertn;
            exc_ecode    <= sel_ecode;
            exc_esubcode <= sel_sub;
            exc_pc       <= cmt_pc;
         end
         if (state == REDIRECT && redirect_ack)
            drain_cnt <= DRAIN_LOAD;
         else if (state == DRAIN && drain_cnt != 4'd0)
            drain_cnt <= drain_cnt - 4'd1;
      end
   end

   always_comb begin
      state_nxt    = state;
      cmt_ready    = 1'b0;
      exc_signal   = 1'b0;
      ertn_signal  = 1'b0;
      flush        = 1'b0;
      redirect_req = 1'b0;
      case (state)
         IDLE: begin
            cmt_ready = 1'b1;
            if (accept & (sel_exc | sel_ertn))
               state_nxt = TRAP;
         end
         TRAP: begin
            exc_signal  = is_exc_p1;
            ertn_signal = is_ertn_p1;
            flush       = 1'b1;
            state_nxt   = REDIRECT;
         end
         REDIRECT: begin
            redirect_req = 1'b1;
            flush        = 1'b1;
            if (redirect_ack)
               state_nxt = (DRAIN_CYCLES == 0) ? IDLE : DRAIN;
         end
         DRAIN: begin
            flush = 1'b1;
            if (drain_cnt == 4'd0)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

`ifdef EXC_BADV_EN
   logic badv_we_p1;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         badv_we_p1 <= 1'b0;
         exc_badv   <= 32'd0;
      end else if (accept & (sel_exc | sel_ertn)) begin
         badv_we_p1 <= sel_exc & sel_badv;
         if (sel_exc & sel_badv)
            exc_badv <= sel_badv_val;
      end
   end

   assign exc_badv_we = (state == TRAP) & badv_we_p1;
`else
   logic unused_badv;
   assign unused_badv = ^{cmt_badv, sel_badv, sel_badv_val};
   assign exc_badv_we = 1'b0;
   assign exc_badv    = 32'd0;
`endif

endmodule

// File: tb/tb_exc_sched.sv
// Self-checking bench for exc_sched: directed vector table, reset-in-flight sequence, randomized commits vs. a priority-list model.
`timescale 1ns/1ps
module tb_exc_sched;
   localparam int DC = 2;
`ifdef EXC_BADV_EN
   localparam bit BADV_EN = 1'b1;
`else
   localparam bit BADV_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        cmt_valid = 1'b0;
   logic        cmt_ready;
   logic [31:0] cmt_pc = 32'd0;
   logic [5:0]  cmt_exc = 6'd0;
   logic        cmt_ertn = 1'b0;
   logic [31:0] cmt_badv = 32'd0;
   logic        int_pending = 1'b0;
   logic        cmt_retire;
   logic        exc_signal, ertn_signal;
   logic [5:0]  exc_ecode;
   logic [8:0]  exc_esubcode;
   logic [31:0] exc_pc;
   logic        flush, redirect_req;
   logic        redirect_ack = 1'b0;
   logic        exc_badv_we;
   logic [31:0] exc_badv;

   always #5 clk = ~clk;

   exc_sched #(.DRAIN_CYCLES(DC)) dut (
      .clk(clk), .resetn(resetn),
      .cmt_valid(cmt_valid), .cmt_ready(cmt_ready), .cmt_pc(cmt_pc),
      .cmt_exc(cmt_exc), .cmt_ertn(cmt_ertn), .cmt_badv(cmt_badv),
      .int_pending(int_pending), .cmt_retire(cmt_retire),
      .exc_signal(exc_signal), .ertn_signal(ertn_signal),
      .exc_ecode(exc_ecode), .exc_esubcode(exc_esubcode), .exc_pc(exc_pc),
      .flush(flush), .redirect_req(redirect_req), .redirect_ack(redirect_ack),
      .exc_badv_we(exc_badv_we), .exc_badv(exc_badv)
   );

   int total = 0;
   int bad = 0;

   // values the CSR-facing registers must be holding
   logic [5:0]  h_ecode = 6'd0;
   logic [8:0]  h_sub = 9'd0;
   logic [31:0] h_pc = 32'd0;
   logic [31:0] h_badv = 32'd0;

   typedef struct {
      bit         retire;
      bit         exc;
      bit         ertn;
      logic [5:0] ecode;
      logic [8:0] sub;
   } ev_t;

   typedef struct {
      bit          pend;
      logic [5:0]  exc;
      bit          ertn;
      logic [31:0] pc;
      logic [31:0] badv;
      int          ackdel;
      ev_t         e;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: walk the architectural priority list and take the first event present.
   function automatic ev_t ref_event(input bit pend, input logic [5:0] exc, input bit ertn);
      ev_t r;
      logic [5:0] codes [6];
      codes = '{6'h08, 6'h0D, 6'h0C, 6'h0B, 6'h09, 6'h08};
      r = '{retire: 1'b0, exc: 1'b0, ertn: 1'b0, ecode: 6'd0, sub: 9'd0};
      if (pend) begin
         r.exc = 1'b1;
         return r;
      end
      for (int i = 0; i < 6; i++) begin
         if (exc[i]) begin
            r.exc   = 1'b1;
            r.ecode = codes[i];
            r.sub   = (i == 5) ? 9'd1 : 9'd0;
            return r;
         end
      end
      if (ertn) r.ertn = 1'b1;
      else      r.retire = 1'b1;
      return r;
   endfunction

   task automatic chk_badv(input string tag, input bit we_exp);
      chk({tag, "_badv_we"}, 32'(exc_badv_we), 32'(BADV_EN & we_exp));
      chk({tag, "_badv"}, exc_badv, BADV_EN ? h_badv : 32'd0);
   endtask

   task automatic do_txn(input vec_t v);
      bit          bwe;
      logic [31:0] bval;
      bwe  = v.e.exc && (v.e.ecode == 6'h08 || v.e.ecode == 6'h09);
      bval = (v.e.ecode == 6'h08 && v.e.sub == 9'd0) ? v.pc : v.badv;

      @(negedge clk);
      cmt_valid = 1'b1; int_pending = v.pend; cmt_exc = v.exc; cmt_ertn = v.ertn;
      cmt_pc = v.pc; cmt_badv = v.badv; redirect_ack = 1'b0;
      #1;
      chk("ready_T", 32'(cmt_ready), 32'd1);
      chk("retire_T", 32'(cmt_retire), 32'(v.e.retire));

      @(negedge clk);
      if (v.e.retire) begin
         cmt_valid = 1'b0;
         #1;
         chk("ret_exc_signal", 32'(exc_signal), 32'd0);
         chk("ret_flush", 32'(flush), 32'd0);
         chk("ret_ready", 32'(cmt_ready), 32'd1);
         chk("ret_ecode_hold", 32'(exc_ecode), 32'(h_ecode));
         return;
      end

      h_ecode = v.e.ecode; h_sub = v.e.sub; h_pc = v.pc;
      if (bwe) h_badv = bval;
      // new commits and interrupts offered while busy must be ignored
      cmt_valid = 1'b1; int_pending = 1'($urandom); cmt_exc = 6'($urandom);
      cmt_ertn = 1'($urandom); cmt_pc = $urandom; cmt_badv = $urandom;
      #1;
      chk("trap_exc_signal", 32'(exc_signal), 32'(v.e.exc));
      chk("trap_ertn_signal", 32'(ertn_signal), 32'(v.e.ertn));
      chk("trap_flush", 32'(flush), 32'd1);
      chk("trap_ready", 32'(cmt_ready), 32'd0);
      chk("trap_retire", 32'(cmt_retire), 32'd0);
      chk("trap_redirect_req", 32'(redirect_req), 32'd0);
      chk("trap_ecode", 32'(exc_ecode), 32'(v.e.ecode));
      chk("trap_esubcode", 32'(exc_esubcode), 32'(v.e.sub));
      chk("trap_pc", exc_pc, v.pc);
      chk_badv("trap", bwe);

      for (int i = 0; i <= v.ackdel; i++) begin
         @(negedge clk);
         redirect_ack = (i == v.ackdel);
         #1;
         chk("redir_req", 32'(redirect_req), 32'd1);
         chk("redir_flush", 32'(flush), 32'd1);
         chk("redir_pulses", 32'({exc_signal, ertn_signal, exc_badv_we}), 32'd0);
         chk("redir_retire", 32'(cmt_retire), 32'd0);
      end

      for (int i = 0; i < DC; i++) begin
         @(negedge clk);
         redirect_ack = 1'b0;
         #1;
         chk("drain_flush", 32'(flush), 32'd1);
         chk("drain_redirect_req", 32'(redirect_req), 32'd0);
         chk("drain_ready", 32'(cmt_ready), 32'd0);
      end

      @(negedge clk);
      cmt_valid = 1'b0; redirect_ack = 1'b0;
      #1;
      chk("idle_ready", 32'(cmt_ready), 32'd1);
      chk("idle_flush", 32'(flush), 32'd0);
      chk("idle_ecode_hold", 32'(exc_ecode), 32'(h_ecode));
      chk("idle_sub_hold", 32'(exc_esubcode), 32'(h_sub));
      chk("idle_pc_hold", exc_pc, h_pc);
      chk_badv("idle", 1'b0);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_ready"}, 32'(cmt_ready), 32'd1);
      chk({tag, "_ctrl"}, 32'({exc_signal, ertn_signal, flush, redirect_req, exc_badv_we}), 32'd0);
      chk({tag, "_ecode"}, 32'(exc_ecode), 32'd0);
      chk({tag, "_esubcode"}, 32'(exc_esubcode), 32'd0);
      chk({tag, "_pc"}, exc_pc, 32'd0);
      chk({tag, "_badv"}, exc_badv, 32'd0);
   endtask

   vec_t vt[10];
   vec_t rv;

   initial begin
      vt[0] = '{0, 6'b000000, 0, 32'h1c000010, 32'h0,        0, '{1, 0, 0, 6'h00, 9'd0}};
      vt[1] = '{0, 6'b001100, 0, 32'h1c000020, 32'h0,        1, '{0, 1, 0, 6'h0C, 9'd0}};
      vt[2] = '{1, 6'b010000, 0, 32'h1c000030, 32'h00000003, 0, '{0, 1, 0, 6'h00, 9'd0}};
      vt[3] = '{0, 6'b000000, 1, 32'h1c000040, 32'h0,        3, '{0, 0, 1, 6'h00, 9'd0}};
      vt[4] = '{0, 6'b100000, 0, 32'h1c000050, 32'h80000000, 0, '{0, 1, 0, 6'h08, 9'd1}};
      vt[5] = '{0, 6'b000001, 0, 32'h1c000060, 32'hdeadbeef, 2, '{0, 1, 0, 6'h08, 9'd0}};
      vt[6] = '{0, 6'b110010, 0, 32'h1c000070, 32'h12345678, 0, '{0, 1, 0, 6'h0D, 9'd0}};
      vt[7] = '{0, 6'b010000, 1, 32'h1c000080, 32'h00000011, 1, '{0, 1, 0, 6'h09, 9'd0}};
      vt[8] = '{1, 6'b000000, 1, 32'h1c000090, 32'h0,        0, '{0, 1, 0, 6'h00, 9'd0}};
      vt[9] = '{0, 6'b000000, 0, 32'h1c0000a0, 32'h0,        0, '{1, 0, 0, 6'h00, 9'd0}};

      resetn = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk_reset_outputs("rst");
      resetn = 1'b1;

      for (int i = 0; i < 10; i++) do_txn(vt[i]);

      // reset while the redirect is outstanding; a late ack must not move the FSM
      @(negedge clk);
      cmt_valid = 1'b1; int_pending = 1'b0; cmt_exc = 6'b000100; cmt_ertn = 1'b0;
      cmt_pc = 32'h1c0000b0; cmt_badv = 32'h0;
      @(negedge clk);
      cmt_valid = 1'b0;
      @(negedge clk);
      #1;
      chk("mid_redirect_req", 32'(redirect_req), 32'd1);
      resetn = 1'b0;
      @(negedge clk);
      resetn = 1'b1; redirect_ack = 1'b1;
      #1;
      chk_reset_outputs("midrst");
      h_ecode = 6'd0; h_sub = 9'd0; h_pc = 32'd0; h_badv = 32'd0;
      @(negedge clk);
      redirect_ack = 1'b0;
      #1;
      chk("late_ack_ready", 32'(cmt_ready), 32'd1);
      chk("late_ack_ctrl", 32'({flush, redirect_req, exc_signal}), 32'd0);

      for (int n = 0; n < 40; n++) begin
         rv.pend   = ($urandom_range(0, 4) == 0);
         rv.exc    = 6'($urandom) & 6'($urandom) & 6'($urandom);
         rv.ertn   = 1'($urandom);
         rv.pc     = $urandom;
         rv.badv   = $urandom;
         rv.ackdel = $urandom_range(0, 3);
         rv.e      = ref_event(rv.pend, rv.exc, rv.ertn);
         do_txn(rv);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/exc_sched.md
# exc_sched

Exception/interrupt sequencer sitting between the commit (WB) point of the five-stage LoongArch pipeline and the CSR file. It accepts one committing instruction per cycle, arbitrates among that instruction's exception flags, ERTN and a pending interrupt, then sequences the trap. Sequencing covers a one-cycle CSR update pulse, a redirect handshake with IF and a pipeline-drain window. While a trap is in flight, commit is back-pressured, so the CSR file never sees two overlapping trap events.

## Interface
- DRAIN_CYCLES, 2, cycles `flush` stays high after the redirect is acknowledged (0..15)
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- cmt_valid  in  1  an instruction is presented at commit
- cmt_ready  out  1  sequencer accepts commit this cycle
- cmt_pc  in  32  PC of the committing instruction
- cmt_exc  in  6  exception flags: [0] ADEF, [1] INE, [2] BRK, [3] SYS, [4] ALE, [5] ADEM
- cmt_ertn  in  1  committing instruction is ERTN
- cmt_badv  in  32  faulting data address, used for ALE and ADEM
- int_pending  in  1  interrupt request (CSR INT_signal)
- cmt_retire  out  1  instruction retires normally (register/memory effects permitted)
- exc_signal  out  1  one-cycle trap pulse to the CSR file
- ertn_signal  out  1  one-cycle ERTN pulse to the CSR file
- exc_ecode  out  6  Ecode of the trap
- exc_esubcode  out  9  EsubCode of the trap
- exc_pc  out  32  PC written to ERA
- flush  out  1  kill all younger pipeline contents
- redirect_req  out  1  IF must fetch from the CSR redirect PC
- redirect_ack  in  1  IF has taken the redirect
- exc_badv_we, exc_badv  out  1, 32  BADV update (see Configuration)

## Operation
- States: IDLE, TRAP, REDIRECT, DRAIN.
- `cmt_ready` = (state==IDLE).
- Accept condition: `cmt_valid & cmt_ready`.
- Event selection on accept, in fixed priority:
  1. INT (ecode 0x00), when `int_pending`
  2. ADEF (0x08, sub 0)
  3. INE (0x0D)
  4. BRK (0x0C)
  5. SYS (0x0B)
  6. ALE (0x09)
  7. ADEM (0x08, sub 1)
  8. ERTN
  9. none
- Interrupts are taken only on an accepted commit slot. The interrupted instruction does not retire, and `exc_pc`=`cmt_pc`.
- `cmt_retire` = accept & no selected event. It is combinational, and it is the only commit effect when no event is selected. The state stays IDLE.
- Exception or ERTN selected: latch ecode, esubcode, pc and badv source, then go to TRAP.
- TRAP, one cycle:
  - `exc_signal`=1 for an exception, `ertn_signal`=1 for ERTN, never both.
  - `flush`=1.
  - Next state is REDIRECT.
- REDIRECT: `redirect_req`=1 and `flush`=1, held until `redirect_ack`. On ack, go to DRAIN (or to IDLE when DRAIN_CYCLES==0).
- DRAIN: `flush`=1. A 4-bit down-counter is loaded with DRAIN_CYCLES-1 on entry. The state exits to IDLE in the cycle after the counter reads 0.
- `exc_ecode`/`exc_esubcode`/`exc_pc` are registered. They hold their last trap value and are valid whenever `exc_signal` or `ertn_signal` is high. For ERTN, ecode/esubcode are 0 and `exc_pc`=`cmt_pc`.
- `int_pending` and new `cmt_valid` are ignored outside IDLE.
- Reset values: state IDLE; counter 0; `exc_signal`, `ertn_signal`, `flush`, `redirect_req`, `exc_badv_we` all 0; `exc_ecode`, `exc_esubcode`, `exc_pc`, `exc_badv` all 0.
- Reset asserted mid-sequence: the next cycle is IDLE with all outputs at reset values. An outstanding `redirect_ack` is ignored.

## Timing
- Exception accepted at cycle T:
  - T+1: `exc_signal` and `flush`.
  - T+2: `redirect_req`, held until ack.
  - Ack at cycle A: DRAIN occupies A+1..A+DRAIN_CYCLES, and IDLE (`cmt_ready`=1) resumes at A+DRAIN_CYCLES+1.
- `redirect_ack` already high at T+2 gives a minimum REDIRECT length of 1 cycle.
- `cmt_retire` has zero latency (combinational) and is high only in IDLE.
- Back-to-back: the earliest next accept is A+DRAIN_CYCLES+1.
- Minimum total busy time with DRAIN_CYCLES=2: 4 cycles.

## Configuration
- EXC_BADV_EN defined: `exc_badv_we` pulses together with `exc_signal` for ADEF, ALE and ADEM.
  - ADEF: `exc_badv`=`cmt_pc`.
  - ALE/ADEM: `exc_badv`=`cmt_badv`.
  - `exc_badv` is registered and held.
- EXC_BADV_EN undefined: `exc_badv_we` and `exc_badv` are tied to 0, and no badv registers exist.

## Test plan
- Commit pc=0x1c000010, `cmt_exc`=0, `int_pending`=0 -> `cmt_retire`=1 same cycle, no `exc_signal`, state stays IDLE.
- Commit pc=0x1c000020, `cmt_exc`=6'b001100 (BRK+SYS) -> at T+1, `exc_signal`=1 for one cycle with ecode=0x0C, `exc_pc`=0x1c000020; `cmt_ready`=0 until the drain completes.
- Commit with `cmt_exc`[4]=1, `cmt_badv`=0x00000003, `int_pending`=1 -> ecode=0x00 (interrupt wins); with EXC_BADV_EN defined, `exc_badv_we`=0.
- ERTN commit, `redirect_ack` delayed 3 cycles, DRAIN_CYCLES=2 -> `ertn_signal` at T+1, `redirect_req` at T+2..T+5, `flush` high T+1..T+7, `cmt_ready`=1 at T+8.
- ADEM commit with `cmt_badv`=0x8000_0000, EXC_BADV_EN defined -> ecode=0x08, esubcode=1, `exc_badv`=0x80000000 with `exc_badv_we` coincident with `exc_signal`.
- `resetn`=0 during REDIRECT -> next cycle all outputs 0 and `cmt_ready`=1; an ack arriving afterward causes no transition.
